// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencer: register-field type, hazard FSM states
// and the packed control word that drives the PC and the four pipeline latches.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DWAIT,
    HZ_HALT
  } hzstate_t;

  // Latch vectors are ordered {ifid, idex, exmem, memwb}.
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_FREEZE = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b0000};

  function automatic hz_ctrl_t hz_ctrl(input logic pc_en, input logic [3:0] en,
                                       input logic [3:0] flush);
    hz_ctrl_t c;
    c.pc_en = pc_en;
    c.en    = en;
    c.flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source read in ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_ex_dren,
  input  regbits_t i_ex_wsel,
  input  regbits_t i_id_rs,
  input  regbits_t i_id_rt,
  input  logic     i_id_uses_rt,
  output logic     o_lu
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_wsel == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_wsel == i_id_rt);

  // $zero is never a real dependency.
  assign o_lu = i_ex_dren && (i_ex_wsel != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: PC/latch enables and flushes, DWAIT/HALT tracking,
// saturating stall/flush counters and a sticky data-wait watchdog.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wd_err
);

  localparam int unsigned WdW = $clog2(DWAIT_MAX + 1);

  hzstate_t         r_state;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [WdW-1:0]   r_wd_cnt;
  logic             r_wd_err;

  hzstate_t w_next;
  hz_ctrl_t w_ctrl;
  logic     w_mem_acc;
  logic     w_lu;
  logic     w_miss;
  logic     w_redirect_taken;

  hazard_detect u_hazard_detect (
    .i_ex_dren   (ex_dREN),
    .i_ex_wsel   (ex_wsel),
    .i_id_rs     (id_rs),
    .i_id_rt     (id_rt),
    .i_id_uses_rt(id_uses_rt),
    .o_lu        (w_lu)
  );

  assign w_mem_acc = mem_dREN || mem_dWEN;

  always_comb begin
    w_ctrl           = HZ_FREEZE;
    w_next           = r_state;
    w_miss           = 1'b0;
    w_redirect_taken = 1'b0;
    if (RST || r_state == HZ_HALT) begin
      w_ctrl = HZ_FREEZE;
    end else if (mem_halt) begin
      // Let the halting instruction retire into WB, squash everything younger.
      w_ctrl = hz_ctrl(1'b0, 4'b0001, 4'b1110);
      w_next = HZ_HALT;
    end else if (w_mem_acc && !dhit) begin
      w_miss = 1'b1;
      w_next = HZ_DWAIT;
    end else if (w_mem_acc) begin
      // Dcache owns the memory port this cycle, so no fetch: bubble into IF/ID.
      w_next = HZ_RUN;
      if (mem_redirect) begin
        w_ctrl           = hz_ctrl(1'b1, 4'b0111, 4'b1110);
        w_redirect_taken = 1'b1;
      end else begin
        w_ctrl = hz_ctrl(1'b0, 4'b0111, 4'b1000);
      end
    end else if (mem_redirect) begin
      w_ctrl           = hz_ctrl(1'b1, 4'b1111, 4'b1110);
      w_redirect_taken = 1'b1;
    end else if (w_lu) begin
      w_ctrl = hz_ctrl(1'b0, 4'b0011, 4'b0100);
    end else if (!ihit) begin
      w_ctrl = hz_ctrl(1'b0, 4'b0111, 4'b1000);
    end else begin
      w_ctrl = hz_ctrl(1'b1, 4'b1111, 4'b0000);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= HZ_RUN;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wd_cnt    <= '0;
      r_wd_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HZ_HALT);
      if (r_state != HZ_HALT && !w_ctrl.pc_en && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_redirect_taken && r_flush_cnt != '1) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_miss) begin
        if (r_wd_cnt != WdW'(DWAIT_MAX)) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
        if (r_wd_cnt == WdW'(DWAIT_MAX - 1)) begin
          r_wd_err <= 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.en[3];
  assign idex_en     = w_ctrl.en[2];
  assign exmem_en    = w_ctrl.en[1];
  assign memwb_en    = w_ctrl.en[0];
  assign ifid_flush  = w_ctrl.flush[3];
  assign idex_flush  = w_ctrl.flush[2];
  assign exmem_flush = w_ctrl.flush[1];
  assign memwb_flush = w_ctrl.flush[0];
  assign halted      = r_halted;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign wd_err      = r_wd_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog and narrow counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt;
  logic             ex_dREN, id_uses_rt;
  logic [4:0]       ex_wsel, id_rs, id_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted, wd_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wd_err(wd_err)
  );

  // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
  logic [8:0] ctrl;
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0; id_uses_rt = 1'b0;
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    cyc();
    cyc();
    chk("reset_ctrl", 16'(ctrl), 16'h000);
    chk("reset_halted", 16'(halted), 16'h0);
    chk("reset_stall", 16'(stall_cnt), 16'h0);
    chk("reset_flush", 16'(flush_cnt), 16'h0);
    chk("reset_wd", 16'(wd_err), 16'h0);
    RST = 1'b0;
    #1;
    chk("run_idle", 16'(ctrl), 16'(9'b1_1111_0000));
    cyc();

    ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_rs", 16'(ctrl), 16'(9'b0_0011_0100));
    cyc();
    ex_wsel = 5'd0;
    #1;
    chk("lu_zero_reg", 16'(ctrl), 16'(9'b1_1111_0000));
    cyc();
    ex_wsel = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    chk("lu_rt", 16'(ctrl), 16'(9'b0_0011_0100));
    cyc();
    id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 16'(ctrl), 16'(9'b1_1111_0000));
    cyc();
    chk("stall_after_lu", 16'(stall_cnt), 16'd2);

    idle();
    ihit = 1'b0;
    #1;
    chk("imiss", 16'(ctrl), 16'(9'b0_0111_1000));
    cyc();
    chk("stall_after_imiss", 16'(stall_cnt), 16'd3);

    ihit = 1'b1; mem_dREN = 1'b1;
    #1;
    chk("dmiss_freeze", 16'(ctrl), 16'(9'b0_0000_0000));
    cyc();
    cyc();
    #1;
    chk("dwait_freeze", 16'(ctrl), 16'(9'b0_0000_0000));
    cyc();
    chk("stall_dwait", 16'(stall_cnt), 16'd6);
    chk("wd_not_yet", 16'(wd_err), 16'h0);
    dhit = 1'b1;
    #1;
    chk("dhit_release", 16'(ctrl), 16'(9'b0_0111_1000));
    cyc();
    chk("stall_dhit", 16'(stall_cnt), 16'd7);
    idle();
    #1;
    chk("back_to_run", 16'(ctrl), 16'(9'b1_1111_0000));

    mem_redirect = 1'b1; ihit = 1'b0;
    #1;
    chk("redirect", 16'(ctrl), 16'(9'b1_1111_1110));
    cyc();
    chk("flush_cnt_1", 16'(flush_cnt), 16'd1);
    mem_dREN = 1'b1; dhit = 1'b1;
    #1;
    chk("redirect_dhit", 16'(ctrl), 16'(9'b1_0111_1110));
    cyc();
    chk("flush_cnt_2", 16'(flush_cnt), 16'd2);
    chk("stall_redirects", 16'(stall_cnt), 16'd7);

    idle();
    mem_dWEN = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("wd_three", 16'(wd_err), 16'h0);
    cyc();
    chk("wd_four", 16'(wd_err), 16'h1);
    cyc();
    cyc();
    chk("wd_six", 16'(wd_err), 16'h1);
    dhit = 1'b1;
    cyc();
    chk("wd_sticky", 16'(wd_err), 16'h1);
    chk("stall_wd", 16'(stall_cnt), 16'd14);

    idle();
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("stall_saturate", 16'(stall_cnt), 16'hF);

    idle();
    mem_halt = 1'b1;
    #1;
    chk("halt_entry", 16'(ctrl), 16'(9'b0_0001_1110));
    chk("halt_not_yet", 16'(halted), 16'h0);
    cyc();
    mem_halt = 1'b0;
    #1;
    chk("halted", 16'(halted), 16'h1);
    chk("halt_frozen", 16'(ctrl), 16'h000);
    mem_redirect = 1'b1;
    cyc();
    cyc();
    chk("halt_hold", 16'(ctrl), 16'h000);
    chk("halt_no_redirect", 16'(flush_cnt), 16'd2);
    chk("halted_hold", 16'(halted), 16'h1);

    idle();
    RST = 1'b1;
    #1;
    chk("rst_ctrl", 16'(ctrl), 16'h000);
    cyc();
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_stall", 16'(stall_cnt), 16'h0);
    chk("rst_flush", 16'(flush_cnt), 16'h0);
    chk("rst_wd", 16'(wd_err), 16'h0);
    RST = 1'b0;
    #1;
    chk("rst_run", 16'(ctrl), 16'(9'b1_1111_0000));
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
